// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO push arbiter.
// Imported by the top-level arbiter and its rotating picker.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first asserted request
// found when scanning base, base+1, ... modulo N_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] base,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0]            rot_req;
    logic [N_REQ-1:0][IDX_W-1:0] rot_idx;

    // Position gi of the rotated view corresponds to request (base + gi) mod N_REQ.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, base} + (IDX_W+1)'(gi);
            assign rot_idx[gi]  = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                            : IDX_W'(sum);
            assign rot_req[gi]  = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        any = |req;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                idx = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one sync_fifo push port among N_REQ producers,
// granting bursts of up to MAX_BURST pushes and stalling while the FIFO is full.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [DATA_W-1:0]         fifo_data,
    output logic                      grant_valid,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_reg, state_next;
    logic [ID_W-1:0]  owner_reg, owner_next;
    logic [ID_W-1:0]  rr_base_reg, rr_base_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic              pick_any;
    logic [ID_W-1:0]   pick_idx;
    logic              transfer;
    logic              last_beat;
    logic [DATA_W-1:0] req_bytes [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req  (req_valid),
        .base (rr_base_reg),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign last_beat = (beat_cnt_reg == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ARB_IDLE;
            owner_reg    <= '0;
            rr_base_reg  <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_base_reg  <= rr_base_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_base_next  = rr_base_reg;
        beat_cnt_next = beat_cnt_reg;
        req_ready     = '0;
        fifo_push     = 1'b0;
        fifo_data     = '0;
        grant_valid   = 1'b0;
        grant_id      = '0;
        transfer      = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                // Arbitration cycle only; the winner starts moving data next cycle.
                if (pick_any) begin
                    owner_next    = pick_idx;
                    beat_cnt_next = '0;
                    state_next    = ARB_OWN;
                end
            end
            ARB_OWN: begin
                grant_valid          = 1'b1;
                grant_id             = owner_reg;
                req_ready[owner_reg] = ~fifo_full;
                transfer             = req_valid[owner_reg] & ~fifo_full;
                if (transfer) begin
                    fifo_push     = 1'b1;
                    fifo_data     = req_bytes[owner_reg];
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
                // Full only stalls; a dropped valid or the final beat ends the grant.
                if (!req_valid[owner_reg] || (transfer && last_beat)) begin
                    state_next   = ARB_IDLE;
                    rr_base_next = (owner_reg == ID_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: directed scenarios plus a
// randomized run against a queue-free behavioural model of the arbitration rules.
module tb_fifo_push_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, b_req_valid;
    logic [N*W-1:0] req_data, b_req_data;
    logic [N-1:0]   req_ready, b_req_ready;
    logic           fifo_full, b_fifo_full;
    logic           fifo_push, b_fifo_push;
    logic [W-1:0]   fifo_data, b_fifo_data;
    logic           grant_valid, b_grant_valid;
    logic [1:0]     grant_id, b_grant_id;

    int checks   = 0;
    int failures = 0;
    int hs_cnt [N];
    int b_cnt  [N];

    always #5 clk = ~clk;

    fifo_push_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_push(fifo_push),
        .fifo_data(fifo_data), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    fifo_push_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_ready(b_req_ready), .fifo_full(b_fifo_full), .fifo_push(b_fifo_push),
        .fifo_data(b_fifo_data), .grant_valid(b_grant_valid), .grant_id(b_grant_id)
    );

    // Producers advance to their next byte on each accepted handshake.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst) begin
                hs_cnt[i] <= 0;
                b_cnt[i]  <= 0;
            end else begin
                if (req_valid[i] && req_ready[i])     hs_cnt[i] <= hs_cnt[i] + 1;
                if (b_req_valid[i] && b_req_ready[i]) b_cnt[i]  <= b_cnt[i] + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task drive_data;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W]   = 8'(i * 16 + hs_cnt[i]);
            b_req_data[i*W +: W] = 8'(i * 16 + b_cnt[i]);
        end
    endtask

    task do_reset;
        @(negedge clk);
        rst = 1'b0; req_valid = '0; b_req_valid = '0; fifo_full = 1'b0; b_fifo_full = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task test_reset;
        rst = 1'b0; fifo_full = 1'b0; b_fifo_full = 1'b0;
        req_valid = '1; b_req_valid = '1; req_data = '0; b_req_data = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, fifo_push, fifo_data, grant_valid, grant_id} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0000", {req_ready, fifo_push, fifo_data, grant_valid, grant_id});
        end
        checks++;
        if ({b_req_ready, b_fifo_push, b_fifo_data, b_grant_valid, b_grant_id} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs_b1: got %h expected 0000", {b_req_ready, b_fifo_push, b_fifo_data, b_grant_valid, b_grant_id});
        end
        rst = 1'b1;
        drive_data();
        #1;
        checks++;
        if ({req_ready, fifo_push, grant_valid} !== 6'h0) begin
            failures++;
            $display("FAIL reset_idle_cycle: got ready=%b push=%b gv=%b expected all 0", req_ready, fifo_push, grant_valid);
        end
        @(negedge clk);
        drive_data();
        #1;
        checks++;
        if ({grant_valid, grant_id, fifo_push, fifo_data} !== {1'b1, 2'd0, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL reset_first_grant: got gv=%b id=%0d push=%b data=%h expected gv=1 id=0 push=1 data=00", grant_valid, grant_id, fifo_push, fifo_data);
        end
        checks++;
        if ({b_grant_valid, b_grant_id} !== {1'b1, 2'd0}) begin
            failures++;
            $display("FAIL reset_first_grant_b1: got gv=%b id=%0d expected gv=1 id=0", b_grant_valid, b_grant_id);
        end
    endtask

    task test_single_producer;
        logic [7:0] d [3];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001; req_data = '0; req_data[7:0] = d[0];
        #1;
        checks++;
        if (req_ready !== 4'b0000 || grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_arb_cycle: got ready=%b gv=%b expected ready=0000 gv=0", req_ready, grant_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_data[7:0] = d[i];
            #1;
            checks++;
            if ({req_ready, fifo_push, fifo_data, grant_valid, grant_id} !== {4'b0001, 1'b1, d[i], 1'b1, 2'd0}) begin
                failures++;
                $display("FAIL single_beat%0d: got ready=%b push=%b data=%h gv=%b id=%0d expected ready=0001 push=1 data=%h gv=1 id=0",
                         i, req_ready, fifo_push, fifo_data, grant_valid, grant_id, d[i]);
            end
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (fifo_push !== 1'b0 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_release: got push=%b gv=%b expected push=0 gv=1", fifo_push, grant_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_after: got gv=%b expected 0", grant_valid);
        end
    endtask

    task test_all_producers;
        int pushes;
        int exp_id;
        logic exp_gv;
        logic [7:0] exp_data;
        pushes = 0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            req_valid = '1;
            drive_data();
            #1;
            exp_gv   = (c % 5) != 0;
            exp_id   = exp_gv ? (c / 5) % 4 : 0;
            exp_data = exp_gv ? 8'(exp_id * 16 + (c % 5) - 1 + 4 * (c / 20)) : 8'h00;
            checks++;
            if ({grant_valid, grant_id, fifo_push, fifo_data} !== {exp_gv, 2'(exp_id), exp_gv, exp_data}) begin
                failures++;
                $display("FAIL all_cycle%0d: got gv=%b id=%0d push=%b data=%h expected gv=%b id=%0d push=%b data=%h",
                         c, grant_valid, grant_id, fifo_push, fifo_data, exp_gv, exp_id, exp_gv, exp_data);
            end
            if (fifo_push && c < 20) pushes++;
        end
        req_valid = '0;
        checks++;
        if (pushes != 16) begin
            failures++;
            $display("FAIL all_push_count: got %0d pushes in 20 cycles expected 16", pushes);
        end
    endtask

    task test_full_stall;
        int pushes;
        logic exp_push, exp_gv;
        logic [7:0] exp_data;
        pushes = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req_valid = 4'b0100;
            fifo_full = (c >= 3 && c <= 5);
            drive_data();
            #1;
            exp_push = (c == 1 || c == 2 || c == 6 || c == 7);
            exp_gv   = (c >= 1 && c <= 7);
            exp_data = !exp_push ? 8'h00 : (c < 3 ? 8'(8'h20 + c - 1) : 8'(8'h20 + c - 4));
            checks++;
            if ({req_ready, fifo_push, fifo_data, grant_valid, grant_id} !==
                {(exp_push ? 4'b0100 : 4'b0000), exp_push, exp_data, exp_gv, (exp_gv ? 2'd2 : 2'd0)}) begin
                failures++;
                $display("FAIL full_cycle%0d: got ready=%b push=%b data=%h gv=%b id=%0d expected push=%b data=%h gv=%b",
                         c, req_ready, fifo_push, fifo_data, grant_valid, grant_id, exp_push, exp_data, exp_gv);
            end
            if (fifo_push) pushes++;
        end
        req_valid = '0; fifo_full = 1'b0;
        checks++;
        if (pushes != 4) begin
            failures++;
            $display("FAIL full_burst_total: got %0d pushes expected 4", pushes);
        end
    endtask

    task test_drop_valid;
        logic       e_gv   [6];
        int         e_id   [6];
        logic       e_push [6];
        logic [7:0] e_data [6];
        logic [3:0] e_rdy  [6];
        e_gv   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        e_id   = '{0, 1, 1, 1, 0, 3};
        e_push = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        e_data = '{8'h00, 8'h10, 8'h11, 8'h00, 8'h00, 8'h30};
        e_rdy  = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = (c < 3) ? 4'b1010 : 4'b1000;
            drive_data();
            #1;
            checks++;
            if ({req_ready, fifo_push, fifo_data, grant_valid, grant_id} !== {e_rdy[c], e_push[c], e_data[c], e_gv[c], 2'(e_id[c])}) begin
                failures++;
                $display("FAIL drop_cycle%0d: got ready=%b push=%b data=%h gv=%b id=%0d expected ready=%b push=%b data=%h gv=%b id=%0d",
                         c, req_ready, fifo_push, fifo_data, grant_valid, grant_id, e_rdy[c], e_push[c], e_data[c], e_gv[c], e_id[c]);
            end
        end
        req_valid = '0;
    endtask

    task test_reset_mid_burst;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req_valid = (c < 5) ? 4'b0010 : 4'b1110;
            drive_data();
        end
        #1;
        checks++;
        if ({grant_valid, grant_id, fifo_push} !== {1'b1, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL midrst_before: got gv=%b id=%0d push=%b expected gv=1 id=2 push=1", grant_valid, grant_id, fifo_push);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, fifo_push, fifo_data, grant_valid, grant_id} !== 16'h0) begin
            failures++;
            $display("FAIL midrst_async: got %h expected 0000", {req_ready, fifo_push, fifo_data, grant_valid, grant_id});
        end
        @(negedge clk);
        rst = 1'b1;
        drive_data();
        #1;
        checks++;
        if ({fifo_push, grant_valid} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_idle: got push=%b gv=%b expected 0 0", fifo_push, grant_valid);
        end
        @(negedge clk);
        drive_data();
        #1;
        checks++;
        if ({grant_valid, grant_id, fifo_push, fifo_data} !== {1'b1, 2'd1, 1'b1, 8'h10}) begin
            failures++;
            $display("FAIL midrst_regrant: got gv=%b id=%0d push=%b data=%h expected gv=1 id=1 push=1 data=10",
                     grant_valid, grant_id, fifo_push, fifo_data);
        end
        req_valid = '0;
    endtask

    task test_max_burst_one;
        logic [7:0] got [$];
        logic [7:0] want [4];
        logic exp_gv;
        int   exp_id;
        want = '{8'h00, 8'h10, 8'h01, 8'h11};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            b_req_valid = 4'b0011;
            drive_data();
            #1;
            exp_gv = (c % 2) == 1;
            exp_id = exp_gv ? (c / 2) % 2 : 0;
            checks++;
            if ({b_grant_valid, b_grant_id, b_fifo_push} !== {exp_gv, 2'(exp_id), exp_gv}) begin
                failures++;
                $display("FAIL burst1_cycle%0d: got gv=%b id=%0d push=%b expected gv=%b id=%0d push=%b",
                         c, b_grant_valid, b_grant_id, b_fifo_push, exp_gv, exp_id, exp_gv);
            end
            if (b_fifo_push) got.push_back(b_fifo_data);
        end
        b_req_valid = '0;
        checks++;
        if (got.size() != 4) begin
            failures++;
            $display("FAIL burst1_count: got %0d pushes expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    failures++;
                    $display("FAIL burst1_order%0d: got %h expected %h", i, got[i], want[i]);
                end
            end
        end
    endtask

    // Model: owner = -1 when nobody holds the FIFO; a grant ends after MAX_BURST
    // accepted bytes or as soon as the owner stops offering.
    task test_random;
        int m_owner, m_beats, m_base, nxt;
        logic xfer;
        logic [15:0] exp_v;
        logic [7:0]  pdata [N];
        do_reset();
        m_owner = -1; m_beats = 0; m_base = 0;
        for (int i = 0; i < N; i++) pdata[i] = 8'($urandom);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                req_valid[i]       = ($urandom_range(0, 9) < 7);
                req_data[i*W +: W] = pdata[i];
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            #1;
            xfer  = 1'b0;
            exp_v = 16'h0;
            if (m_owner >= 0) begin
                xfer  = req_valid[m_owner] && !fifo_full;
                exp_v = {(fifo_full ? 4'b0000 : 4'(1 << m_owner)), xfer, (xfer ? pdata[m_owner] : 8'h00), 1'b1, 2'(m_owner)};
            end
            checks++;
            if ({req_ready, fifo_push, fifo_data, grant_valid, grant_id} !== exp_v) begin
                failures++;
                $display("FAIL random_cycle%0d: got %h expected %h (valid=%b full=%b)",
                         c, {req_ready, fifo_push, fifo_data, grant_valid, grant_id}, exp_v, req_valid, fifo_full);
            end
            if (m_owner < 0) begin
                nxt = -1;
                for (int k = 0; k < N; k++) begin
                    if (nxt < 0 && req_valid[(m_base + k) % N]) nxt = (m_base + k) % N;
                end
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_beats = 0;
                end
            end else begin
                if (xfer) begin
                    m_beats++;
                    pdata[m_owner] = 8'($urandom);
                end
                if (!req_valid[m_owner] || m_beats == 4) begin
                    m_base  = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
        req_valid = '0; fifo_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_producer();
        test_all_producers();
        test_full_stall();
        test_drop_valid();
        test_reset_mid_burst();
        test_max_burst_one();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin write arbiter that shares a single `sync_fifo` push port between `N_REQ` producers. Each producer offers bytes over a valid/ready handshake. The arbiter grants ownership of the FIFO to one producer at a time for a burst of up to `MAX_BURST` pushes, and stalls all producers while the FIFO reports `full`. It sits directly in front of `sync_fifo` and drives its `push` and `data_in` inputs. The FIFO's `pop` side is not touched.

## Interface
- `N_REQ`, default 4: number of producers, 2..8.
- `DATA_W`, default 8: data width; matches `sync_fifo` `data_in`.
- `MAX_BURST`, default 4: maximum pushes per grant, at least 1.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `req_valid`  in  N_REQ  producer i has a byte on its slice of `req_data`.
- `req_data`  in  N_REQ*DATA_W  slice i is bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ  one-hot or zero; the byte from producer i is accepted when `req_valid[i] & req_ready[i]`.
- `fifo_full`  in  1  from `sync_fifo` `full`.
- `fifo_push`  out  1  to `sync_fifo` `push`.
- `fifo_data`  out  DATA_W  to `sync_fifo` `data_in`.
- `grant_valid`  out  1  a producer currently owns the FIFO.
- `grant_id`  out  $clog2(N_REQ)  index of the owner; 0 when `grant_valid` = 0.

## Operation
- States: `ARB_IDLE`, `ARB_OWN`. Registers: `state`, `owner`, `rr_base`, `beat_cnt`. `beat_cnt` is `$clog2(MAX_BURST+1)` bits wide.
- Reset: `state`=IDLE, `owner`=0, `rr_base`=0, `beat_cnt`=0. All outputs are 0: `req_ready`, `fifo_push`, `fifo_data`, `grant_valid`, `grant_id`.
- IDLE with any `req_valid` set:
  - Pick the first asserted index scanning `rr_base`, `rr_base+1`, … modulo `N_REQ`.
  - Load `owner`, clear `beat_cnt`, go to OWN.
  - No transfer happens in the IDLE cycle.
- IDLE with no `req_valid`: stay in IDLE.
- OWN:
  - `req_ready[owner]` = `~fifo_full`. All other `req_ready` bits are 0.
  - Transfer = `req_valid[owner] & ~fifo_full`.
  - `fifo_push` = transfer. `fifo_data` = `req_data[owner]` when transfer is 1, otherwise 0. Both are combinational.
  - Each transfer increments `beat_cnt`.
- Release from OWN: go to IDLE and set `rr_base` = `owner+1` mod `N_REQ` on either condition:
  - a transfer occurs while `beat_cnt == MAX_BURST-1`, or
  - `req_valid[owner]` = 0 in an OWN cycle, regardless of `fifo_full`.
- `fifo_full` in OWN: hold ownership, no transfer, `beat_cnt` unchanged. Full never causes release.
- Producer rule: `req_valid[i]` and its data must hold until accepted. Lowering `req_valid` forfeits the grant and does not drop data.
- `grant_valid` = (state == OWN). `grant_id` = `owner` in OWN, otherwise 0.
- Reset asserted mid-burst: the state is cleared immediately and outputs go to 0. No partial push is issued.

## Timing
- Arbitration latency: 1 cycle. `req_valid` rising in IDLE produces `req_ready` in the next cycle.
- Throughput inside a burst: 1 byte per cycle while `~fifo_full`.
- Burst overhead: 1 idle cycle between grants. Peak utilisation is `MAX_BURST/(MAX_BURST+1)`.
- `fifo_push` appears in the same cycle as the handshake, so `sync_fifo` captures the byte on that edge.
- `fifo_full` acts combinationally on the same cycle. `sync_fifo` never sees `push` with `full`=1.
- Fairness: a continuously requesting producer waits at most `(N_REQ-1)*(MAX_BURST+1)` cycles plus full stalls.

## Structure
- Package `fifo_arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t`
  - default constants `N_REQ_DEF`, `DATA_W_DEF`, `MAX_BURST_DEF`
- Sub-module `rr_pick`: combinational rotating-priority picker.
  - Inputs: `req[N_REQ]`, `base`.
  - Outputs: `any`, `idx`.
  - Instantiated once.

## Test plan
- Single producer 0 sends 0x11, 0x22, 0x33 back to back, FIFO not full:
  - `req_ready[0]` is high one cycle after `req_valid`.
  - Three consecutive `fifo_push` pulses with data 0x11, 0x22, 0x33.
  - `grant_id` = 0 throughout.
- All 4 producers valid continuously, `MAX_BURST`=4:
  - Grant order 0, 1, 2, 3, 0.
  - Each burst is exactly 4 pushes, with 1 idle cycle between bursts.
  - The FIFO receives 16 bytes in 20 cycles.
- Owner 2 mid-burst, `fifo_full` forced high for 3 cycles:
  - `fifo_push` and `req_ready` stay 0 and `grant_id` stays 2.
  - After full drops, the remaining beats complete and the total is still 4.
- Owner 1 drops `req_valid` after 2 beats while producer 3 is waiting:
  - Release in that cycle, then IDLE.
  - Next grant goes to 3, since `rr_base` = 2 and 2 is idle.
- `rst` pulsed low during a burst:
  - All outputs go to 0 asynchronously.
  - After release, the first grant goes to the lowest valid index starting from 0.
- `MAX_BURST`=1 with producers 0 and 1 valid:
  - Grants alternate 0, 1, 0, 1 with 1 push per grant.
  - The FIFO data order matches the grant order.
